// File: rtl/abro_sequencer.sv
// Table-driven stimulus sequencer for an ABRO machine: plays up to 16 programmed
// Reset/A/B steps and scores the returned O against a per-step expected bit.
module abro_sequencer #(
   parameter int HOLD_CYCLES = 1,
   parameter int CHECK_LAT   = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       prog_we,
   input  logic [3:0] prog_addr,
   input  logic [3:0] prog_data,
   input  logic       start,
   input  logic [4:0] num_steps,
   input  logic       abro_o,
   output logic       abro_reset,
   output logic       abro_a,
   output logic       abro_b,
   output logic       busy,
   output logic       done,
   output logic [4:0] pass_cnt,
   output logic [4:0] fail_cnt,
   output logic       fail_seen,
   output logic [3:0] first_fail
);

   localparam int DEPTH = HOLD_CYCLES + CHECK_LAT;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t     state, state_n;
   logic [3:0] tbl [16];
   logic [3:0] step, step_n;
   logic [3:0] hold, hold_n;
   logic [2:0] drain, drain_n;
   logic [4:0] len, len_n, len_req;
   logic [2:0] drv_n;
   logic       busy_n, done_n, accept, wr_en;
   logic       push, push_exp;
   logic [3:0] push_idx, entry0;

   logic [DEPTH-1:0]      vld_pipe, exp_pipe;
   logic [DEPTH-1:0][3:0] idx_pipe;

   assign wr_en   = prog_we && !busy;
   assign len_req = (num_steps > 5'd16) ? 5'd16 : num_steps;
   // A write landing on the start edge must be seen by step 0.
   assign entry0  = (wr_en && prog_addr == 4'd0) ? prog_data : tbl[0];

   always_comb begin
      state_n  = state;
      step_n   = step;
      hold_n   = hold;
      drain_n  = drain;
      len_n    = len;
      drv_n    = {abro_reset, abro_a, abro_b};
      busy_n   = busy;
      done_n   = 1'b0;
      accept   = 1'b0;
      push     = 1'b0;
      push_idx = step;
      push_exp = 1'b0;
      case (state)
         IDLE: begin
            drv_n = 3'b100;
            if (start) begin
               accept  = 1'b1;
               len_n   = len_req;
               busy_n  = 1'b1;
               step_n  = 4'd0;
               hold_n  = 4'd0;
               drain_n = 3'd0;
               if (len_req == 5'd0) begin
                  state_n = DRAIN;
                  drv_n   = 3'b000;
               end else begin
                  state_n  = RUN;
                  drv_n    = entry0[3:1];
                  push     = 1'b1;
                  push_idx = 4'd0;
                  push_exp = entry0[0];
               end
            end
         end
         RUN: begin
            if (hold == 4'(HOLD_CYCLES - 1)) begin
               hold_n = 4'd0;
               if ({1'b0, step} == len - 5'd1) begin
                  state_n = DRAIN;
                  drain_n = 3'd0;
                  drv_n   = 3'b000;
               end else begin
                  step_n   = step + 4'd1;
                  drv_n    = tbl[step + 4'd1][3:1];
                  push     = 1'b1;
                  push_idx = step + 4'd1;
                  push_exp = tbl[step + 4'd1][0];
               end
            end else begin
               hold_n = hold + 4'd1;
            end
         end
         DRAIN: begin
            drv_n = 3'b000;
            if (drain == 3'(CHECK_LAT - 1)) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               drv_n   = 3'b100;
            end else begin
               drain_n = drain + 3'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         step       <= 4'd0;
         hold       <= 4'd0;
         drain      <= 3'd0;
         len        <= 5'd0;
         abro_reset <= 1'b1;
         abro_a     <= 1'b0;
         abro_b     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         step       <= step_n;
         hold       <= hold_n;
         drain      <= drain_n;
         len        <= len_n;
         {abro_reset, abro_a, abro_b} <= drv_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) tbl[i] <= 4'd0;
      end else if (wr_en) begin
         tbl[prog_addr] <= prog_data;
      end
   end

   // Expected bit, step index and valid flag ride along until O is due.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         exp_pipe <= '0;
         idx_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[DEPTH-2:0], push};
         exp_pipe <= {exp_pipe[DEPTH-2:0], push_exp};
         idx_pipe <= {idx_pipe[DEPTH-2:0], push_idx};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pass_cnt   <= 5'd0;
         fail_cnt   <= 5'd0;
         fail_seen  <= 1'b0;
         first_fail <= 4'd0;
      end else if (accept) begin
         pass_cnt   <= 5'd0;
         fail_cnt   <= 5'd0;
         fail_seen  <= 1'b0;
         first_fail <= 4'd0;
      end else if (vld_pipe[DEPTH-1]) begin
         if (abro_o == exp_pipe[DEPTH-1]) begin
            pass_cnt <= pass_cnt + 5'd1;
         end else begin
            fail_cnt <= fail_cnt + 5'd1;
            if (!fail_seen) begin
               fail_seen  <= 1'b1;
               first_fail <= idx_pipe[DEPTH-1];
            end
         end
      end
   end

endmodule
